// File: rtl/if_id_fetch_queue.sv
// if_id_fetch_queue: decoupling FIFO of {pc, instr} between fetch and decode.
// Optional macro IFQ_PERF_CNT_EN adds a saturating decode-starvation counter.
module if_id_fetch_queue #(
    parameter int DEPTH   = 4,
    parameter int PC_W    = 32,
    parameter int INSTR_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     enq_valid,
    output logic                     enq_ready,
    input  logic [PC_W-1:0]          enq_pc,
    input  logic [INSTR_W-1:0]       enq_instr,
    output logic                     deq_valid,
    input  logic                     deq_ready,
    output logic [PC_W-1:0]          deq_pc,
    output logic [PC_W-1:0]          deq_pc_plus4,
    output logic [INSTR_W-1:0]       deq_instr,
    output logic [$clog2(DEPTH):0]   count,
    output logic [31:0]              perf_starve_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [PC_W-1:0]    r_mem_pc    [DEPTH];
    logic [INSTR_W-1:0] r_mem_instr [DEPTH];
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [CW-1:0]      r_count;

    logic               w_enq_ready;
    logic               w_deq_valid;
    logic               w_enq_fire;
    logic               w_deq_fire;
    logic [PC_W-1:0]    w_head_pc;
    logic [INSTR_W-1:0] w_head_instr;

    // Full blocks fetch regardless of a same-cycle dequeue, keeping
    // enq_ready off any combinational path from decode.
    assign w_enq_ready  = (r_count != FULL);
    assign w_deq_valid  = (r_count != '0) & ~flush;
    assign w_enq_fire   = enq_valid & w_enq_ready & ~flush;
    assign w_deq_fire   = w_deq_valid & deq_ready;
    assign w_head_pc    = r_mem_pc[r_rd_ptr];
    assign w_head_instr = r_mem_instr[r_rd_ptr];

    assign enq_ready    = w_enq_ready;
    assign deq_valid    = w_deq_valid;
    assign deq_pc       = w_head_pc;
    assign deq_pc_plus4 = w_head_pc + PC_W'(4);
    assign deq_instr    = w_deq_valid ? w_head_instr : '0;
    assign count        = r_count;

    // Storage: written only by an accepted enqueue; flush leaves it stale.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_pc[i]    <= '0;
                r_mem_instr[i] <= '0;
            end
        end else if (w_enq_fire) begin
            r_mem_pc[r_wr_ptr]    <= enq_pc;
            r_mem_instr[r_wr_ptr] <= enq_instr;
        end
    end

    // Write pointer: wraps naturally since DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
        end else if (w_enq_fire) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
        end
    end

    // Read pointer: advances on each word handed to decode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr <= '0;
        end else if (flush) begin
            r_rd_ptr <= '0;
        end else if (w_deq_fire) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
        end
    end

    // Occupancy: enq alone grows, deq alone shrinks, both together hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (flush) begin
            r_count <= '0;
        end else if (w_enq_fire && !w_deq_fire) begin
            r_count <= r_count + CW'(1);
        end else if (w_deq_fire && !w_enq_fire) begin
            r_count <= r_count - CW'(1);
        end
    end

`ifdef IFQ_PERF_CNT_EN
    logic [31:0] r_starve_cnt;

    // Counts edges where decode asked for a word and none was offered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_starve_cnt <= '0;
        end else if (deq_ready && !w_deq_valid && (r_starve_cnt != '1)) begin
            r_starve_cnt <= r_starve_cnt + 32'd1;
        end
    end

    assign perf_starve_cnt = r_starve_cnt;
`else
    assign perf_starve_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_if_id_fetch_queue.sv
// tb_if_id_fetch_queue: directed and random checks of the fetch queue
// against a queue-based reference model.
module tb_if_id_fetch_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        enq_valid = 1'b0;
    logic        enq_ready;
    logic [31:0] enq_pc = '0;
    logic [31:0] enq_instr = '0;
    logic        deq_valid;
    logic        deq_ready = 1'b0;
    logic [31:0] deq_pc;
    logic [31:0] deq_pc_plus4;
    logic [31:0] deq_instr;
    logic [2:0]  count;
    logic [31:0] perf_starve_cnt;

    logic [63:0] m_q[$];
    int          m_starve = 0;
    int          n_checks = 0;
    int          n_err = 0;

    if_id_fetch_queue #(.DEPTH(DEPTH), .PC_W(32), .INSTR_W(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .enq_valid(enq_valid), .enq_ready(enq_ready),
        .enq_pc(enq_pc), .enq_instr(enq_instr),
        .deq_valid(deq_valid), .deq_ready(deq_ready),
        .deq_pc(deq_pc), .deq_pc_plus4(deq_pc_plus4),
        .deq_instr(deq_instr), .count(count),
        .perf_starve_cnt(perf_starve_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic drive(input logic ev, input logic [31:0] pc,
                         input logic [31:0] ins, input logic dr,
                         input logic fl);
        enq_valid = ev;
        enq_pc    = pc;
        enq_instr = ins;
        deq_ready = dr;
        flush     = fl;
        #1;
    endtask

    // Advance one edge and apply the queue rules to the model.
    task automatic tick();
        logic mv;
        logic mr;
        mv = (m_q.size() != 0) && !flush;
        mr = (m_q.size() < DEPTH);
        if (deq_ready && !mv) m_starve++;
        @(posedge clk);
        if (flush) begin
            m_q.delete();
        end else begin
            if (mv && deq_ready) void'(m_q.pop_front());
            if (enq_valid && mr) m_q.push_back({enq_pc, enq_instr});
        end
        #1;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0);
        rst = 1'b1;
        m_q.delete();
        m_starve = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (enq_ready !== 1'b1) begin n_err++; $display("FAIL rst_enq_ready: got %b want 1", enq_ready); end
        n_checks++; if (deq_valid !== 1'b0) begin n_err++; $display("FAIL rst_deq_valid: got %b want 0", deq_valid); end
        n_checks++; if (deq_instr !== 32'h0) begin n_err++; $display("FAIL rst_deq_instr: got %h want 0", deq_instr); end
        n_checks++; if (count !== 3'd0) begin n_err++; $display("FAIL rst_count: got %0d want 0", count); end
        n_checks++; if (deq_pc !== 32'h0) begin n_err++; $display("FAIL rst_deq_pc: got %h want 0", deq_pc); end
        n_checks++; if (deq_pc_plus4 !== 32'h4) begin n_err++; $display("FAIL rst_pc_plus4: got %h want 4", deq_pc_plus4); end
        n_checks++; if (perf_starve_cnt !== 32'h0) begin n_err++; $display("FAIL rst_perf: got %0d want 0", perf_starve_cnt); end
    endtask

    task automatic test_single();
        drive(1, 32'h0040_0000, 32'h2008_0005, 0, 0);
        n_checks++; if (deq_valid !== 1'b0) begin n_err++; $display("FAIL single_no_bypass: got %b want 0", deq_valid); end
        tick();
        drive(0, 0, 0, 0, 0);
        n_checks++; if (deq_valid !== 1'b1) begin n_err++; $display("FAIL single_valid: got %b want 1", deq_valid); end
        n_checks++; if (deq_pc !== 32'h0040_0000) begin n_err++; $display("FAIL single_pc: got %h want 00400000", deq_pc); end
        n_checks++; if (deq_pc_plus4 !== 32'h0040_0004) begin n_err++; $display("FAIL single_pc4: got %h want 00400004", deq_pc_plus4); end
        n_checks++; if (deq_instr !== 32'h2008_0005) begin n_err++; $display("FAIL single_instr: got %h want 20080005", deq_instr); end
        n_checks++; if (count !== 3'd1) begin n_err++; $display("FAIL single_count: got %0d want 1", count); end
        drive(0, 0, 0, 1, 0);
        tick();
        drive(0, 0, 0, 0, 0);
        n_checks++; if (count !== 3'd0) begin n_err++; $display("FAIL single_drain: got %0d want 0", count); end
    endtask

    task automatic test_fill_wrap();
        logic [31:0] base;
        logic [31:0] exp_ins;
        for (int r = 0; r < 2; r++) begin
            base = 32'h0040_0000 + 32'(r * 16);
            for (int i = 0; i < DEPTH; i++) begin
                drive(1, base + 32'(4 * i), $urandom, 0, 0);
                tick();
            end
            drive(1, 32'hDEAD_0000, 32'hBAD0_BAD0, 0, 0);
            n_checks++; if (count !== 3'd4) begin n_err++; $display("FAIL full_count: got %0d want 4", count); end
            n_checks++; if (enq_ready !== 1'b0) begin n_err++; $display("FAIL full_ready: got %b want 0", enq_ready); end
            tick();
            n_checks++; if (count !== 3'd4) begin n_err++; $display("FAIL full_5th_ignored: got %0d want 4", count); end
            for (int i = 0; i < DEPTH; i++) begin
                drive(i == 0, 32'hDEAD_0004, 32'hBAD0_BAD1, 1, 0);
                exp_ins = m_q[0][31:0];
                n_checks++; if (deq_pc !== base + 32'(4 * i)) begin n_err++; $display("FAIL order_pc: got %h want %h", deq_pc, base + 32'(4 * i)); end
                n_checks++; if (deq_instr !== exp_ins) begin n_err++; $display("FAIL order_instr: got %h want %h", deq_instr, exp_ins); end
                if (i == 0) begin
                    n_checks++; if (enq_ready !== 1'b0) begin n_err++; $display("FAIL full_deq_ready: got %b want 0", enq_ready); end
                end
                tick();
            end
            drive(0, 0, 0, 1, 0);
            n_checks++; if (count !== 3'd0) begin n_err++; $display("FAIL fill_empty: got %0d want 0", count); end
            n_checks++; if (deq_valid !== 1'b0) begin n_err++; $display("FAIL fill_empty_valid: got %b want 0", deq_valid); end
            tick();
            n_checks++; if (count !== 3'd0) begin n_err++; $display("FAIL empty_deq_ignored: got %0d want 0", count); end
        end
    endtask

    task automatic test_stream();
        drive(1, 32'h0000_1000, 32'h1111_0000, 0, 0);
        tick();
        drive(1, 32'h0000_1004, 32'h1111_0001, 0, 0);
        tick();
        for (int k = 0; k < 10; k++) begin
            drive(1, 32'h0000_1008 + 32'(4 * k), 32'h1111_0002 + 32'(k), 1, 0);
            n_checks++; if (count !== 3'd2) begin n_err++; $display("FAIL stream_count: got %0d want 2", count); end
            n_checks++; if (deq_pc !== 32'h0000_1000 + 32'(4 * k)) begin n_err++; $display("FAIL stream_pc: got %h want %h", deq_pc, 32'h0000_1000 + 32'(4 * k)); end
            n_checks++; if (deq_instr !== 32'h1111_0000 + 32'(k)) begin n_err++; $display("FAIL stream_instr: got %h want %h", deq_instr, 32'h1111_0000 + 32'(k)); end
            tick();
        end
        drive(0, 0, 0, 1, 0);
        n_checks++; if (count !== 3'd2) begin n_err++; $display("FAIL stream_end_count: got %0d want 2", count); end
        tick();
        tick();
        drive(0, 0, 0, 0, 0);
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h0000_2000 + 32'(4 * i), 32'h2222_0000 + 32'(i), 0, 0);
            tick();
        end
        drive(1, 32'h0000_3000, 32'hDEAD_BEEF, 1, 1);
        n_checks++; if (deq_valid !== 1'b0) begin n_err++; $display("FAIL flush_cycle_valid: got %b want 0", deq_valid); end
        n_checks++; if (deq_instr !== 32'h0) begin n_err++; $display("FAIL flush_cycle_instr: got %h want 0", deq_instr); end
        tick();
        drive(0, 0, 0, 0, 0);
        n_checks++; if (count !== 3'd0) begin n_err++; $display("FAIL flush_count: got %0d want 0", count); end
        n_checks++; if (deq_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid: got %b want 0", deq_valid); end
        tick();
        n_checks++; if (deq_valid !== 1'b0) begin n_err++; $display("FAIL flush_stays_empty: got %b want 0", deq_valid); end
        drive(1, 32'h0000_4000, 32'h4444_4444, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0);
        n_checks++; if (deq_pc !== 32'h0000_4000) begin n_err++; $display("FAIL flush_next_pc: got %h want 00004000", deq_pc); end
        n_checks++; if (count !== 3'd1) begin n_err++; $display("FAIL flush_next_count: got %0d want 1", count); end
        drive(0, 0, 0, 1, 0);
        tick();
        drive(0, 0, 0, 0, 0);
    endtask

    task automatic test_rst_mid();
        drive(1, 32'h0000_5000, 32'h5555_5555, 0, 0);
        tick();
        tick();
        drive(0, 0, 0, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if (count !== 3'd0) begin n_err++; $display("FAIL rst_mid_count: got %0d want 0", count); end
        n_checks++; if (deq_valid !== 1'b0) begin n_err++; $display("FAIL rst_mid_valid: got %b want 0", deq_valid); end
        n_checks++; if (enq_ready !== 1'b1) begin n_err++; $display("FAIL rst_mid_ready: got %b want 1", enq_ready); end
        m_q.delete();
        m_starve = 0;
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic test_perf();
        logic [31:0] exp5;
`ifdef IFQ_PERF_CNT_EN
        exp5 = 32'd5;
`else
        exp5 = 32'd0;
`endif
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, 1, 0);
            tick();
        end
        drive(0, 0, 0, 0, 0);
        n_checks++; if (perf_starve_cnt !== exp5) begin n_err++; $display("FAIL perf_starve: got %0d want %0d", perf_starve_cnt, exp5); end
        drive(1, 32'h0000_6000, 32'h6666_6666, 0, 0);
        tick();
        drive(0, 0, 0, 0, 1);
        tick();
        drive(0, 0, 0, 0, 0);
        n_checks++; if (perf_starve_cnt !== exp5) begin n_err++; $display("FAIL perf_after_flush: got %0d want %0d", perf_starve_cnt, exp5); end
    endtask

    task automatic test_random();
        logic        ev, dr, fl, mv;
        logic [31:0] epc, einst, eperf;
        for (int c = 0; c < 400; c++) begin
            ev = 1'($urandom);
            dr = 1'($urandom);
            fl = ($urandom_range(0, 15) == 0);
            drive(ev, $urandom, $urandom, dr, fl);
            mv = (m_q.size() != 0) && !fl;
            epc = (m_q.size() != 0) ? m_q[0][63:32] : 32'h0;
            einst = mv ? m_q[0][31:0] : 32'h0;
`ifdef IFQ_PERF_CNT_EN
            eperf = 32'(m_starve);
`else
            eperf = 32'h0;
`endif
            n_checks++; if (count !== 3'(m_q.size())) begin n_err++; $display("FAIL rnd_count: got %0d want %0d", count, m_q.size()); end
            n_checks++; if (deq_valid !== mv) begin n_err++; $display("FAIL rnd_valid: got %b want %b", deq_valid, mv); end
            n_checks++; if (enq_ready !== (m_q.size() < DEPTH)) begin n_err++; $display("FAIL rnd_ready: got %b want %b", enq_ready, m_q.size() < DEPTH); end
            n_checks++; if (deq_instr !== einst) begin n_err++; $display("FAIL rnd_instr: got %h want %h", deq_instr, einst); end
            n_checks++; if (perf_starve_cnt !== eperf) begin n_err++; $display("FAIL rnd_perf: got %0d want %0d", perf_starve_cnt, eperf); end
            if (mv) begin
                n_checks++; if (deq_pc !== epc) begin n_err++; $display("FAIL rnd_pc: got %h want %h", deq_pc, epc); end
                n_checks++; if (deq_pc_plus4 !== epc + 32'd4) begin n_err++; $display("FAIL rnd_pc4: got %h want %h", deq_pc_plus4, epc + 32'd4); end
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_wrap();
        test_stream();
        test_flush();
        test_rst_mid();
        test_perf();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
